// File: rtl/mem32_arb.sv
// mem32_arb: two-requester arbiter in front of a byte-wide memory port.
// A read transaction assembles a 32-bit word from four byte reads at
// addresses 0..3; a write transaction presents one 32-bit word and waits
// for the memory's write-complete flag, aborting after WR_TIMEOUT cycles.
// Optional feature macro: MEM32_ARB_RR_EN
//   defined   -> round-robin arbitration on simultaneous requests
//   undefined -> fixed priority, requester 0 wins every tie
module mem32_arb #(
    parameter int WR_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        m_rd,
    output logic        m_wr,
    output logic [1:0]  m_addr,
    output logic [31:0] m_indata,
    input  logic [7:0]  m_dataout,
    input  logic        m_valid
);

    // Counter wide enough to hold WR_TIMEOUT-1.
    localparam int CW = (WR_TIMEOUT > 1) ? $clog2(WR_TIMEOUT) : 1;
    localparam logic [CW-1:0] WR_LAST = CW'(WR_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    state_t          state_r;
    logic            owner_r;     // 0 = requester 0 owns the bus, 1 = requester 1
    logic [CW-1:0]   wr_cnt_r;    // write cycles already spent without m_valid
    logic [2:0]      rd_cnt_r;    // index of the current READ cycle (0..4)
    logic            pick1_s;     // arbitration result: 1 = requester 1 wins
    logic            sel_we_s;    // write-enable of the pending owner
    logic [31:0]     sel_wdata_s; // write word of the pending owner
    logic [1:0]      byte_idx_s;  // byte captured in the current READ cycle

`ifdef MEM32_ARB_RR_EN
    // Requester granted most recently; reset value 1 lets requester 0 win first.
    logic            last_gnt_r;
`endif

    // Choose the winner among the active requests.
    always_comb begin
        pick1_s = 1'b0;
        if (req0 && req1) begin
`ifdef MEM32_ARB_RR_EN
            pick1_s = ~last_gnt_r;
`else
            pick1_s = 1'b0;
`endif
        end else if (req1) begin
            pick1_s = 1'b1;
        end else begin
            pick1_s = 1'b0;
        end
    end

    // Route the owner's command fields and derive the byte lane being captured.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_wdata_s = 32'h0000_0000;
        if (owner_r) begin
            sel_we_s    = we1;
            sel_wdata_s = wdata1;
        end else begin
            sel_we_s    = we0;
            sel_wdata_s = wdata0;
        end
        byte_idx_s = 2'(rd_cnt_r - 3'd1);
    end

`ifdef MEM32_ARB_RR_EN
    // Remember which requester was granted last for round-robin ties.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_r <= 1'b1;
        end else if (state_r == ST_IDLE && (req0 || req1)) begin
            last_gnt_r <= pick1_s;
        end else begin
            last_gnt_r <= last_gnt_r;
        end
    end
`endif

    // Transaction FSM with all bus and handshake outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            owner_r  <= 1'b0;
            wr_cnt_r <= '0;
            rd_cnt_r <= 3'd0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            err0     <= 1'b0;
            err1     <= 1'b0;
            rdata0   <= 32'h0000_0000;
            rdata1   <= 32'h0000_0000;
            m_rd     <= 1'b0;
            m_wr     <= 1'b0;
            m_addr   <= 2'd0;
            m_indata <= 32'h0000_0000;
        end else begin
            // Completion flags are single-cycle pulses.
            done0 <= 1'b0;
            done1 <= 1'b0;
            err0  <= 1'b0;
            err1  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        owner_r <= pick1_s;
                        gnt0    <= ~pick1_s;
                        gnt1    <= pick1_s;
                        state_r <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // m_indata doubles as the latched write word for the
                    // whole WRITE phase, so later wdata changes are ignored.
                    if (sel_we_s) begin
                        m_wr     <= 1'b1;
                        m_indata <= sel_wdata_s;
                        wr_cnt_r <= '0;
                        state_r  <= ST_WRITE;
                    end else begin
                        m_rd     <= 1'b1;
                        m_addr   <= 2'd0;
                        rd_cnt_r <= 3'd0;
                        state_r  <= ST_READ;
                    end
                end
                ST_WRITE: begin
                    // A completion on the final allowed cycle still counts.
                    if (m_valid) begin
                        m_wr     <= 1'b0;
                        m_indata <= 32'h0000_0000;
                        wr_cnt_r <= '0;
                        done0    <= ~owner_r;
                        done1    <= owner_r;
                        state_r  <= ST_RESP;
                    end else if (wr_cnt_r == WR_LAST) begin
                        m_wr     <= 1'b0;
                        m_indata <= 32'h0000_0000;
                        wr_cnt_r <= '0;
                        err0     <= ~owner_r;
                        err1     <= owner_r;
                        state_r  <= ST_RESP;
                    end else begin
                        wr_cnt_r <= wr_cnt_r + CW'(1);
                    end
                end
                ST_READ: begin
                    // Memory data lags the address by one cycle, so READ
                    // cycle k (k>=1) holds the byte addressed in cycle k-1.
                    if (rd_cnt_r != 3'd0) begin
                        if (owner_r) begin
                            rdata1[{byte_idx_s, 3'b000} +: 8] <= m_dataout;
                        end else begin
                            rdata0[{byte_idx_s, 3'b000} +: 8] <= m_dataout;
                        end
                    end
                    case (rd_cnt_r)
                        3'd0, 3'd1, 3'd2: begin
                            m_addr   <= 2'(rd_cnt_r + 3'd1);
                            rd_cnt_r <= rd_cnt_r + 3'd1;
                        end
                        3'd3: begin
                            m_rd     <= 1'b0;
                            m_addr   <= 2'd0;
                            rd_cnt_r <= 3'd4;
                        end
                        3'd4: begin
                            rd_cnt_r <= 3'd0;
                            done0    <= ~owner_r;
                            done1    <= owner_r;
                            state_r  <= ST_RESP;
                        end
                        default: begin
                            m_rd     <= 1'b0;
                            m_addr   <= 2'd0;
                            rd_cnt_r <= 3'd0;
                            state_r  <= ST_IDLE;
                        end
                    endcase
                end
                ST_RESP: begin
                    gnt0    <= 1'b0;
                    gnt1    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    gnt0     <= 1'b0;
                    gnt1     <= 1'b0;
                    m_rd     <= 1'b0;
                    m_wr     <= 1'b0;
                    m_addr   <= 2'd0;
                    m_indata <= 32'h0000_0000;
                    wr_cnt_r <= '0;
                    rd_cnt_r <= 3'd0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
